// File: rtl/tjrpu_span_dispatcher.sv
// tjrpu_span_dispatcher: queues horizontal span jobs (y, x_start, x_end) in a
// small FIFO and hands each one to a free tile rasterizer chosen round-robin.
// Spans with x_end < x_start are dropped at the FIFO head.
//
// Optional feature macro: TJRPU_SPAN_STATS_EN adds the saturating
// dispatch_count / drop_count outputs.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   span_valid/span_ready       producer handshake
//   span_y/x_start/x_end        incoming span coordinates
//   tile_done                   per-tile completion pulses
//   tile_start                  per-tile launch pulses (one-hot, one cycle)
//   y/x_start/x_end             per-tile coordinate registers, tile i at [i*COORD_W +: COORD_W]
//   busy_mask                   per-tile busy flags
//   idle                        FIFO empty and no tile busy
//   dispatch_count, drop_count  statistics (TJRPU_SPAN_STATS_EN only)
module tjrpu_span_dispatcher #(
  parameter int unsigned NUM_TILES  = 64,
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           span_valid,
  output logic                           span_ready,
  input  logic [COORD_W-1:0]             span_y,
  input  logic [COORD_W-1:0]             span_x_start,
  input  logic [COORD_W-1:0]             span_x_end,
  input  logic [NUM_TILES-1:0]           tile_done,
  output logic [NUM_TILES-1:0]           tile_start,
  output logic [NUM_TILES*COORD_W-1:0]   y,
  output logic [NUM_TILES*COORD_W-1:0]   x_start,
  output logic [NUM_TILES*COORD_W-1:0]   x_end,
  output logic [NUM_TILES-1:0]           busy_mask,
`ifdef TJRPU_SPAN_STATS_EN
  output logic [31:0]                    dispatch_count,
  output logic [15:0]                    drop_count,
`endif
  output logic                           idle
);

  localparam int unsigned IDX_W = $clog2(NUM_TILES);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x_start;
    logic [COORD_W-1:0] x_end;
  } span_t;

  span_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   rr;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               dispatch;
  logic               drop;
  logic               head_ok;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [NUM_TILES-1:0] win_oh;
  span_t              head;

  // FIFO status comes from registered count only
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign span_ready = !full;
  assign idle       = empty && (busy_mask == '0);
  assign push       = span_valid && !full;

  assign head     = mem[rd_ptr];
  assign head_ok  = (head.x_end >= head.x_start);
  assign drop     = !empty && !head_ok;
  assign dispatch = !empty && head_ok && found;
  assign pop      = dispatch || drop;

  // Round-robin search: first free tile at index >= rr, wrapping through 0
  always_comb begin
    found = 1'b0;
    win   = rr;
    for (int k = 0; k < int'(NUM_TILES); k++) begin
      if (!found && !busy_mask[IDX_W'(rr + IDX_W'(k))]) begin
        found = 1'b1;
        win   = IDX_W'(rr + IDX_W'(k));
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // FIFO storage needs no reset; validity is tracked by count
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {span_y, span_x_start, span_x_end};
  end

  // FIFO pointers, arbitration state and per-tile registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr         <= '0;
      busy_mask  <= '0;
      tile_start <= '0;
      y          <= '0;
      x_start    <= '0;
      x_end      <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

      // Done clears and the winner's set land together; the winner is never a done tile
      busy_mask  <= (busy_mask & ~tile_done) | (dispatch ? win_oh : '0);
      tile_start <= dispatch ? win_oh : '0;
      if (dispatch) rr <= IDX_W'(win + IDX_W'(1));

      for (int i = 0; i < int'(NUM_TILES); i++) begin
        if (dispatch && (win == IDX_W'(i))) begin
          y[i*COORD_W +: COORD_W]       <= head.y;
          x_start[i*COORD_W +: COORD_W] <= head.x_start;
          x_end[i*COORD_W +: COORD_W]   <= head.x_end;
        end
      end
    end
  end

`ifdef TJRPU_SPAN_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dispatch_count <= '0;
      drop_count     <= '0;
    end else begin
      if (dispatch && (dispatch_count != '1)) dispatch_count <= dispatch_count + 32'd1;
      if (drop && (drop_count != '1))         drop_count     <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tjrpu_span_dispatcher.sv
// Testbench for tjrpu_span_dispatcher with NUM_TILES=4: expected dispatches are
// queued when spans are pushed and a negedge monitor compares each tile_start.
module tb_tjrpu_span_dispatcher;

  localparam int unsigned NT = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          span_valid = 1'b0;
  logic          span_ready;
  logic [CW-1:0] span_y = '0;
  logic [CW-1:0] span_xs = '0;
  logic [CW-1:0] span_xe = '0;
  logic [NT-1:0] tile_done = '0;
  logic [NT-1:0] tile_start;
  logic [NT*CW-1:0] y_bus;
  logic [NT*CW-1:0] xs_bus;
  logic [NT*CW-1:0] xe_bus;
  logic [NT-1:0] busy_mask;
  logic          idle;
`ifdef TJRPU_SPAN_STATS_EN
  logic [31:0]   dispatch_count;
  logic [15:0]   drop_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          tile;
    logic [7:0]  y;
    logic [7:0]  xs;
    logic [7:0]  xe;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  tjrpu_span_dispatcher #(.NUM_TILES(NT), .COORD_W(CW), .FIFO_DEPTH(4)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .span_valid   (span_valid),
    .span_ready   (span_ready),
    .span_y       (span_y),
    .span_x_start (span_xs),
    .span_x_end   (span_xe),
    .tile_done    (tile_done),
    .tile_start   (tile_start),
    .y            (y_bus),
    .x_start      (xs_bus),
    .x_end        (xe_bus),
    .busy_mask    (busy_mask),
`ifdef TJRPU_SPAN_STATS_EN
    .dispatch_count (dispatch_count),
    .drop_count     (drop_count),
`endif
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tile_start must match the oldest expected dispatch
  always @(negedge clk) begin
    if (tile_start !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got %b expected none", tile_start);
      end else begin
        mon_e = exp_q.pop_front();
        chk("start_onehot", 32'(tile_start), 32'(1) << mon_e.tile);
        chk("start_y",  32'(y_bus[mon_e.tile*CW +: CW]),  32'(mon_e.y));
        chk("start_xs", 32'(xs_bus[mon_e.tile*CW +: CW]), 32'(mon_e.xs));
        chk("start_xe", 32'(xe_bus[mon_e.tile*CW +: CW]), 32'(mon_e.xe));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Push one span; exp_tile < 0 means no dispatch is expected for it
  task automatic push(input logic [7:0] py, input logic [7:0] pxs, input logic [7:0] pxe,
                      input int exp_tile);
    exp_t e;
    logic ok;
    bit   done;
    done = 1'b0;
    if (exp_tile >= 0) begin
      e.tile = exp_tile; e.y = py; e.xs = pxs; e.xe = pxe;
      exp_q.push_back(e);
    end
    span_valid = 1'b1;
    span_y = py; span_xs = pxs; span_xe = pxe;
    for (int i = 0; i < 40 && !done; i++) begin
      ok = span_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    span_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready=0 expected accept within 40 cycles");
    end
  endtask

  task automatic pulse_done(input logic [NT-1:0] m);
    tile_done = m;
    @(posedge clk);
    #1;
    tile_done = '0;
  endtask

  initial begin
    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_start", 32'(tile_start), 32'h0);
    chk("rst_ready", 32'(span_ready), 32'h1);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_y", y_bus, 32'h0);

    // Single span: tile 0 starts two cycles after accept
    push(8'd5, 8'd10, 8'd20, 0);
    @(negedge clk);
    chk("lat_start_early", 32'(tile_start), 32'h0);
    tick(1);
    @(negedge clk);
    chk("lat_start", 32'(tile_start), 32'h1);
    chk("lat_busy", 32'(busy_mask), 32'h1);
    chk("lat_y0", 32'(y_bus[7:0]), 32'd5);
    tick(1);
    @(negedge clk);
    chk("start_one_cycle", 32'(tile_start), 32'h0);
    chk("coord_hold", 32'(xe_bus[7:0]), 32'd20);

    // Back-to-back spans and round-robin past a freed tile
    reset_dut();
    push(8'd1, 8'd2, 8'd3, 0);
    push(8'd4, 8'd5, 8'd6, 1);
    push(8'd7, 8'd8, 8'd9, 2);
    tick(3);
    @(negedge clk);
    chk("rr_busy3", 32'(busy_mask), 32'h7);
    pulse_done(4'b0010);
    @(negedge clk);
    chk("done_clear", 32'(busy_mask), 32'h5);
    push(8'd10, 8'd11, 8'd12, 3);
    tick(3);
    @(negedge clk);
    chk("after_d", 32'(busy_mask), 32'hD);
    push(8'd13, 8'd14, 8'd15, 1);
    tick(3);
    @(negedge clk);
    chk("all_busy", 32'(busy_mask), 32'hF);

    // All busy: FIFO fills and back-pressures
    push(8'd20, 8'd21, 8'd22, 2);
    push(8'd23, 8'd24, 8'd25, 3);
    push(8'd26, 8'd27, 8'd28, -1);
    push(8'd29, 8'd30, 8'd31, -1);
    @(negedge clk);
    chk("full_ready", 32'(span_ready), 32'h0);
    chk("full_idle", 32'(idle), 32'h0);
    pulse_done(4'b0100);
    @(negedge clk);
    chk("full_ready_hold", 32'(span_ready), 32'h0);
    chk("full_busy_clr", 32'(busy_mask), 32'hB);
    tick(1);
    @(negedge clk);
    chk("ready_back", 32'(span_ready), 32'h1);
    chk("busy_refill", 32'(busy_mask), 32'hF);
    pulse_done(4'b1000);
    tick(3);
    @(negedge clk);
    chk("two_queued_ready", 32'(span_ready), 32'h1);
    chk("two_queued_idle", 32'(idle), 32'h0);

    // Reset mid-operation with spans queued and tiles busy
    reset_dut();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy_mask), 32'h0);
    chk("mid_rst_ready", 32'(span_ready), 32'h1);
    chk("mid_rst_idle", 32'(idle), 32'h1);
    chk("mid_rst_start", 32'(tile_start), 32'h0);
    pulse_done(4'b1111);
    tick(2);
    @(negedge clk);
    chk("stray_done", 32'(busy_mask), 32'h0);
    chk("stray_idle", 32'(idle), 32'h1);

    // Degenerate span is dropped; single-pixel span is dispatched
    push(8'd0, 8'd30, 8'd12, -1);
    @(negedge clk);
    chk("degen_queued", 32'(idle), 32'h0);
    tick(1);
    @(negedge clk);
    chk("degen_idle", 32'(idle), 32'h1);
    chk("degen_busy", 32'(busy_mask), 32'h0);
`ifdef TJRPU_SPAN_STATS_EN
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("dispatch_count", dispatch_count, 32'd0);
`endif
    push(8'd9, 8'd7, 8'd7, 0);
    tick(3);
    pulse_done(4'b0001);
    @(negedge clk);
    chk("pixel_done", 32'(busy_mask), 32'h0);

    // Wrap-around: rr=3 with tiles 3 and 0 busy selects tile 1
    push(8'd40, 8'd1, 8'd2, 1);
    push(8'd41, 8'd1, 8'd2, 2);
    push(8'd42, 8'd1, 8'd2, 3);
    push(8'd43, 8'd1, 8'd2, 0);
    tick(3);
    pulse_done(4'b0110);
    @(negedge clk);
    chk("multi_done", 32'(busy_mask), 32'h9);
    push(8'd50, 8'd3, 8'd4, 1);
    push(8'd51, 8'd3, 8'd4, 2);
    tick(3);
    pulse_done(4'b0010);
    @(negedge clk);
    chk("wrap_setup", 32'(busy_mask), 32'hD);
    push(8'd52, 8'd5, 8'd6, 1);
    tick(3);
    pulse_done(4'b0110);
    push(8'd53, 8'd7, 8'd8, 2);
    tick(3);
    @(negedge clk);
    chk("rr_after_wrap", 32'(busy_mask), 32'hD);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    pulse_done(4'b1111);
    tick(2);
    @(negedge clk);
    chk("final_idle", 32'(idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tjrpu_span_dispatcher.md
Name: tjrpu_span_dispatcher

Overview:
Scheduler that feeds horizontal span jobs (y, x_start, x_end) to the array of tile rasterizer units. Spans are accepted through a valid/ready port into a small FIFO. Each span is assigned to a free tile by round-robin arbitration, which latches that tile's coordinate registers and pulses its start line. The block tracks per-tile busy state from done pulses and sits between the span producer and the per-tile y/x_start/x_end buses.

Parameters:
NUM_TILES, 64, number of tile rasterizer units (power of 2, 2..64)
COORD_W, 8, width of the y, x_start and x_end coordinates
FIFO_DEPTH, 4, span FIFO entries (power of 2, >=2)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset, synchronous, active-high
span_valid  input  1  producer has a span
span_ready  output  1  FIFO can accept a span
span_y  input  COORD_W  span row
span_x_start  input  COORD_W  first pixel column
span_x_end  input  COORD_W  last pixel column, inclusive
tile_done  input  NUM_TILES  one-cycle pulse per tile when its span completes
tile_start  output  NUM_TILES  one-cycle pulse per tile to launch a span
y  output  NUM_TILES*COORD_W  per-tile row register; tile i at bits [i*COORD_W +: COORD_W]
x_start  output  NUM_TILES*COORD_W  per-tile start-column register, same packing
x_end  output  NUM_TILES*COORD_W  per-tile end-column register, same packing
busy_mask  output  NUM_TILES  registered per-tile busy flags
idle  output  1  FIFO empty and busy_mask == 0

Behaviour:
- Single clock wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: tile_start=0, busy_mask=0, y/x_start/x_end=0, FIFO empty (span_ready=1, idle=1), round-robin pointer rr=0.
- Reset mid-operation discards queued spans and clears busy flags. Tiles still running are no longer tracked, and their later tile_done pulses are ignored.
- Accept: a span is written on the edge where span_valid && span_ready. span_ready = !full, derived from registered state only; it does not depend on span_valid.
- FIFO: registered count, read and write pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave the count unchanged. Full blocks pushes; empty blocks pops.
- Degenerate span (x_end < x_start): popped at the FIFO head and dropped. No tile_start is issued, and the drop takes one cycle. x_end == x_start is valid (a single pixel).
- Dispatch, evaluated every cycle using registered busy_mask:
  - Condition: FIFO non-empty, head span valid, and at least one tile has busy_mask==0.
  - Winner = first free tile at index >= rr, wrapping through index 0.
  - On that edge: pop the head; load y/x_start/x_end[winner]; set busy_mask[winner]; tile_start = one-hot(winner) for exactly one cycle; rr = (winner+1) mod NUM_TILES.
  - At most one dispatch per cycle. rr is unchanged when there is no dispatch.
- Latency: a span accepted at edge t produces tile_start at the earliest in the cycle after edge t+1, i.e. one cycle of FIFO latency. No combinational path from span inputs to outputs.
- Per-tile coordinate registers hold their value until the next dispatch to the same tile.
- Done handling:
  - tile_done[i] with busy_mask[i]=1 clears the flag on that edge, so tile i becomes eligible the following cycle.
  - tile_done[i] with busy_mask[i]=0 is ignored.
  - Several done pulses in one cycle are all honoured.
- Simultaneous done on tile i and dispatch in the same cycle: arbitration sees the pre-clear busy_mask, so i cannot win that cycle. The set for the winner and the clears for the done tiles apply together.
- All tiles busy: head span waits, FIFO fills, span_ready drops when count == FIFO_DEPTH.

Optional Feature:
Macro TJRPU_SPAN_STATS_EN.
- Defined: adds outputs dispatch_count (32-bit) and drop_count (16-bit).
  - dispatch_count increments on each tile_start; drop_count increments on each degenerate-span drop.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then push span (y=5, xs=10, xe=20) -> tile_start[0] pulses one cycle, 2 cycles after the accept edge; y[0]=5, x_start[0]=10, x_end[0]=20; busy_mask=...0001; rr=1.
- Push 3 spans back-to-back with all tiles free -> tile_start on tiles 0,1,2 in consecutive cycles; tile_done[1] -> busy_mask[1] clears next cycle; next span goes to tile 3, not 1.
- NUM_TILES=4: fill all tiles, push 4 more spans -> span_ready low after the 4th; tile_done[2] -> next dispatch to tile 2; span_ready high one cycle later.
- Push span xs=30, xe=12 -> no tile_start, FIFO drains, idle=1; with TJRPU_SPAN_STATS_EN, drop_count=1 and dispatch_count unchanged.
- rr=3 with NUM_TILES=4, tiles 3 and 0 busy, tile 1 free -> wrap-around selects tile 1; rr becomes 2.
- Assert wb_rst_i with 2 spans queued and 3 tiles busy -> next cycle busy_mask=0, span_ready=1, idle=1, tile_start=0; a stray tile_done afterwards leaves busy_mask=0.
